// File: rtl/ahb5_pkg.sv
// Shared AHB5 definitions for the manager arbiter.
// Holds the HTRANS/HBURST/HRESP encodings, the arbiter state type, and a helper
// that decodes HBURST into a beat count.
package ahb5_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ARB_FREE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_UNDEF = 2'd2
    } arb_state_e;

    // Beats in a burst; 0 stands for undefined-length INCR.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:                burst_beats = 5'd1;
            HBURST_INCR:                  burst_beats = 5'd0;
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
            default:                      burst_beats = 5'd16;
        endcase
    endfunction

endpackage

// File: rtl/ahb5_rr_arbiter.sv
// Round-robin grant generator with park.
// Ports:
//   clk, rst     clock and synchronous active-high reset (grant resets to manager 0)
//   req          per-manager request vector
//   last_owner   index of the current owner; the search starts just after it
//   update       load a new grant this edge
//   grant        registered one-hot grant
module ahb5_rr_arbiter #(
    parameter int NUM_MGR = 2,
    parameter int IDX_W   = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_MGR-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    input  logic               update,
    output logic [NUM_MGR-1:0] grant
);
    import ahb5_pkg::*;

    localparam int unsigned N = NUM_MGR;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             found;

    // First requester after last_owner wins; with no requester, stay parked.
    always_comb begin
        winner = last_owner;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned i = 1; i < N; i++) begin
            cand = IDX_W'((32'(last_owner) + i) % N);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant <= NUM_MGR'(1);
        end else if (update) begin
            grant <= NUM_MGR'(1) << winner;
        end
    end

endmodule

// File: rtl/ahb5_manager_arbiter.sv
// Shares one AHB5 subordinate between NUM_MGR managers.
// Round-robin grant held for whole bursts; address phase muxed from the granted
// manager, write data/strobes from the data-phase owner; response broadcast.
// Ports:
//   HCLK, HRESET                      clock, synchronous active-high reset
//   M_HREQ / M_HGRANT                 per-manager request / registered one-hot grant
//   M_HADDR..M_HWSTRB                 packed per-manager bus signals, mgr i at [i*W +: W]
//   HRDATA, HREADY, HRESP             response broadcast to all managers
//   S_HSEL, S_H*                      subordinate side address/data phase
//   S_HRDATA, S_HREADYOUT, S_HRESP    subordinate response
module ahb5_manager_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int HBURST_WIDTH = 3,
    parameter int NUM_MGR      = 2
) (
    input  logic                               HCLK,
    input  logic                               HRESET,
    input  logic [NUM_MGR-1:0]                 M_HREQ,
    output logic [NUM_MGR-1:0]                 M_HGRANT,
    input  logic [NUM_MGR*ADDR_WIDTH-1:0]      M_HADDR,
    input  logic [NUM_MGR*2-1:0]               M_HTRANS,
    input  logic [NUM_MGR*HBURST_WIDTH-1:0]    M_HBURST,
    input  logic [NUM_MGR*3-1:0]               M_HSIZE,
    input  logic [NUM_MGR-1:0]                 M_HWRITE,
    input  logic [NUM_MGR*DATA_WIDTH-1:0]      M_HWDATA,
    input  logic [NUM_MGR*DATA_WIDTH/8-1:0]    M_HWSTRB,
    output logic [DATA_WIDTH-1:0]              HRDATA,
    output logic                               HREADY,
    output logic                               HRESP,
    output logic                               S_HSEL,
    output logic [ADDR_WIDTH-1:0]              S_HADDR,
    output logic [1:0]                         S_HTRANS,
    output logic [HBURST_WIDTH-1:0]            S_HBURST,
    output logic [2:0]                         S_HSIZE,
    output logic                               S_HWRITE,
    output logic [DATA_WIDTH-1:0]              S_HWDATA,
    output logic [DATA_WIDTH/8-1:0]            S_HWSTRB,
    input  logic [DATA_WIDTH-1:0]              S_HRDATA,
    input  logic                               S_HREADYOUT,
    input  logic                               S_HRESP
);
    import ahb5_pkg::*;

    localparam int IDX_W  = (NUM_MGR > 1) ? $clog2(NUM_MGR) : 1;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int unsigned N = NUM_MGR;

    arb_state_e       state, state_n;
    logic [4:0]       beat_cnt, beat_n;
    logic [IDX_W-1:0] addr_owner, data_owner;
    logic             data_active;
    logic             accept, rearb, eval_free;
    logic [4:0]       beats;
    htrans_e          owner_trans;

    always_comb begin
        addr_owner = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (M_HGRANT[i]) addr_owner = IDX_W'(i);
        end
    end

    always_comb begin
        S_HADDR  = '0;
        S_HTRANS = '0;
        S_HBURST = '0;
        S_HSIZE  = '0;
        S_HWRITE = 1'b0;
        S_HWDATA = '0;
        S_HWSTRB = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (addr_owner == IDX_W'(i)) begin
                S_HADDR  = M_HADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
                S_HTRANS = M_HTRANS[i*2 +: 2];
                S_HBURST = M_HBURST[i*HBURST_WIDTH +: HBURST_WIDTH];
                S_HSIZE  = M_HSIZE[i*3 +: 3];
                S_HWRITE = M_HWRITE[i];
            end
            if (data_owner == IDX_W'(i)) begin
                S_HWDATA = M_HWDATA[i*DATA_WIDTH +: DATA_WIDTH];
                S_HWSTRB = M_HWSTRB[i*STRB_W +: STRB_W];
            end
        end
    end

    // Idle data phases are answered here with zero-wait OKAY.
    assign HRDATA = S_HRDATA;
    assign HREADY = HRESET | (data_active ? S_HREADYOUT : 1'b1);
    assign HRESP  = (!HRESET && data_active) ? S_HRESP : HRESP_OKAY;
    assign S_HSEL = !HRESET;

    assign accept      = HREADY && !HRESET;
    assign owner_trans = htrans_e'(S_HTRANS);
    assign beats       = burst_beats(3'(S_HBURST));

    always_comb begin
        state_n   = state;
        beat_n    = beat_cnt;
        rearb     = 1'b0;
        eval_free = 1'b0;
        if (accept) begin
            case (state)
                ARB_FREE: eval_free = 1'b1;
                ARB_BURST: begin
                    case (owner_trans)
                        HTRANS_SEQ: begin
                            beat_n = beat_cnt - 5'd1;
                            if (beat_cnt == 5'd1) begin
                                rearb   = 1'b1;
                                state_n = ARB_FREE;
                            end
                        end
                        HTRANS_IDLE: begin
                            rearb   = 1'b1;
                            state_n = ARB_FREE;
                        end
                        HTRANS_NONSEQ: eval_free = 1'b1;
                        default: ;
                    endcase
                end
                ARB_UNDEF: begin
                    case (owner_trans)
                        HTRANS_IDLE: begin
                            rearb   = 1'b1;
                            state_n = ARB_FREE;
                        end
                        HTRANS_NONSEQ: eval_free = 1'b1;
                        default: ;
                    endcase
                end
                default: state_n = ARB_FREE;
            endcase
            // A NONSEQ may start a new burst from any state (early termination).
            if (eval_free) begin
                if (owner_trans == HTRANS_NONSEQ && beats == 5'd0) begin
                    state_n = ARB_UNDEF;
                end else if (owner_trans == HTRANS_NONSEQ && beats > 5'd1) begin
                    state_n = ARB_BURST;
                    beat_n  = beats - 5'd1;
                end else begin
                    state_n = ARB_FREE;
                    rearb   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= ARB_FREE;
            beat_cnt    <= '0;
            data_owner  <= '0;
            data_active <= 1'b0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_n;
            if (accept) begin
                data_owner  <= addr_owner;
                data_active <= S_HTRANS[1];
            end
        end
    end

    ahb5_rr_arbiter #(
        .NUM_MGR (NUM_MGR),
        .IDX_W   (IDX_W)
    ) u_rr (
        .clk        (HCLK),
        .rst        (HRESET),
        .req        (M_HREQ),
        .last_owner (addr_owner),
        .update     (rearb),
        .grant      (M_HGRANT)
    );

endmodule
